// File: rtl/rom_arbiter_if.sv
// Request/response bundle for the two ROM arbiter ports (0 = fetch, 1 = load).
// The arbiter takes the slave side; requesters take the master side.
interface rom_arbiter_if #(
    parameter int unsigned N = 32
);
    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_addr;
    logic         rsp0_valid;
    logic         rsp0_ready;
    logic [N-1:0] rsp0_data;
    logic         rsp0_err;

    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_addr;
    logic         rsp1_valid;
    logic         rsp1_ready;
    logic [N-1:0] rsp1_data;
    logic         rsp1_err;

    modport master (
        output req0_valid, req0_addr, rsp0_ready,
        output req1_valid, req1_addr, rsp1_ready,
        input  req0_ready, rsp0_valid, rsp0_data, rsp0_err,
        input  req1_ready, rsp1_valid, rsp1_data, rsp1_err
    );

    modport slave (
        input  req0_valid, req0_addr, rsp0_ready,
        input  req1_valid, req1_addr, rsp1_ready,
        output req0_ready, rsp0_valid, rsp0_data, rsp0_err,
        output req1_ready, rsp1_valid, rsp1_data, rsp1_err
    );
endinterface

// File: rtl/rom_arbiter.sv
// Two-port round-robin arbiter in front of a single registered-output ROM.
// One access in flight at a time: IDLE -> READ -> RESP -> IDLE.
module rom_arbiter #(
    parameter int unsigned N    = 32,
    parameter int unsigned SIZE = 1024
) (
    input  logic         clk,
    input  logic         rst,
    rom_arbiter_if.slave bus,
    output logic [N-1:0] rom_addr_o,
    input  logic [N-1:0] rom_data_i,
    output logic         busy_o
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRead = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    localparam logic [N:0] AddrLimit = (N+1)'(4 * SIZE);

    logic [1:0]   state_q, state_d;
    logic         owner_q, owner_d;
    logic         last_q, last_d;
    logic         err_q, err_d;
    logic [N-1:0] rom_addr_q, rom_addr_d;
    logic [N-1:0] data_q, data_d;

    logic         idle;
    logic         gnt0, gnt1;
    logic [N-1:0] sel_addr;
    logic         addr_bad;
    logic         rsp_rdy;

    assign idle = (state_q == StIdle);

    // Tie goes to whichever port was not granted last.
    assign gnt0 = bus.req0_valid & (~bus.req1_valid | last_q);
    assign gnt1 = bus.req1_valid & (~bus.req0_valid | ~last_q);

    assign bus.req0_ready = idle & gnt0;
    assign bus.req1_ready = idle & gnt1;

    assign sel_addr = gnt0 ? bus.req0_addr : bus.req1_addr;
    assign addr_bad = (|sel_addr[1:0]) | ({1'b0, sel_addr} >= AddrLimit);
    assign rsp_rdy  = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        err_d      = err_q;
        rom_addr_d = rom_addr_q;
        data_d     = data_q;
        case (state_q)
            StIdle: begin
                if (bus.req0_ready | bus.req1_ready) begin
                    rom_addr_d = sel_addr;
                    owner_d    = gnt1;
                    last_d     = gnt1;
                    err_d      = addr_bad;
                    state_d    = StRead;
                end
            end
            StRead: begin
                data_d  = err_q ? '0 : rom_data_i;
                state_d = StResp;
            end
            StResp: begin
                if (rsp_rdy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            err_q      <= 1'b0;
            rom_addr_q <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            err_q      <= err_d;
            rom_addr_q <= rom_addr_d;
            data_q     <= data_d;
        end
    end

    assign bus.rsp0_valid = (state_q == StResp) & ~owner_q;
    assign bus.rsp1_valid = (state_q == StResp) & owner_q;
    assign bus.rsp0_data  = data_q;
    assign bus.rsp1_data  = data_q;
    assign bus.rsp0_err   = bus.rsp0_valid & err_q;
    assign bus.rsp1_err   = bus.rsp1_valid & err_q;

    assign rom_addr_o = rom_addr_q;
    assign busy_o     = ~idle;
endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: inputs change and outputs are checked just
// after each negedge; a behavioural ROM registers data on the negedge.
module tb_rom_arbiter;
    logic        clk;
    logic        rst;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        busy;
    logic [31:0] mem [0:1023];

    int checks = 0;
    int errors = 0;

    rom_arbiter_if #(.N(32)) bus ();

    rom_arbiter #(.N(32), .SIZE(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .rom_addr_o (rom_addr),
        .rom_data_i (rom_data),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) rom_data <= mem[rom_addr[11:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hCAFE0000 | i;
        mem[2] = 32'hDEADBEEF;
        rom_data = '0;
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.rsp0_ready = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.rsp1_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_rom_addr", rom_addr, 32'h0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp0_valid", bus.rsp0_valid, 0);
        chk("rst_rsp1_valid", bus.rsp1_valid, 0);
        chk("rst_rsp0_data", bus.rsp0_data, 32'h0);
        chk("rst_rsp1_err", bus.rsp1_err, 0);
        rst = 1'b0;

        // Single fetch from port 0, word 2
        bus.req0_valid = 1'b1; bus.req0_addr = 32'h8; bus.rsp0_ready = 1'b1;
        #1;
        chk("t1_req0_ready", bus.req0_ready, 1);
        chk("t1_req1_ready", bus.req1_ready, 0);
        tick();
        bus.req0_valid = 1'b0;
        chk("t1_rom_addr", rom_addr, 32'h8);
        chk("t1_busy_read", busy, 1);
        chk("t1_rsp0_early", bus.rsp0_valid, 0);
        tick();
        chk("t1_rsp0_valid", bus.rsp0_valid, 1);
        chk("t1_rsp0_data", bus.rsp0_data, 32'hDEADBEEF);
        chk("t1_rsp0_err", bus.rsp0_err, 0);
        chk("t1_rsp1_valid", bus.rsp1_valid, 0);
        tick();
        chk("t1_busy_clr", busy, 0);
        chk("t1_rsp0_drop", bus.rsp0_valid, 0);
        chk("t1_rom_addr_hold", rom_addr, 32'h8);

        // Request withdrawn before any posedge sees it
        bus.req0_valid = 1'b1; bus.req0_addr = 32'h10;
        #1;
        chk("t2_ready_seen", bus.req0_ready, 1);
        bus.req0_valid = 1'b0;
        #1;
        tick();
        chk("t2_busy", busy, 0);
        chk("t2_rom_addr", rom_addr, 32'h8);

        // Both ports requesting from reset: grants alternate 0,1,0,1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_addr = 32'h0; bus.rsp0_ready = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_addr = 32'h4; bus.rsp1_ready = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("rr%0d_req0_ready", g), bus.req0_ready, (g % 2 == 0) ? 1 : 0);
            chk($sformatf("rr%0d_req1_ready", g), bus.req1_ready, (g % 2 == 1) ? 1 : 0);
            tick();
            chk($sformatf("rr%0d_no_ready", g), {bus.req0_ready, bus.req1_ready}, 0);
            chk($sformatf("rr%0d_rom_addr", g), rom_addr, (g % 2 == 0) ? 32'h0 : 32'h4);
            tick();
            chk($sformatf("rr%0d_rsp0_valid", g), bus.rsp0_valid, (g % 2 == 0) ? 1 : 0);
            chk($sformatf("rr%0d_rsp1_valid", g), bus.rsp1_valid, (g % 2 == 1) ? 1 : 0);
            chk($sformatf("rr%0d_data", g), bus.rsp0_data,
                (g % 2 == 0) ? 32'hCAFE0000 : 32'hCAFE0001);
            tick();
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        #1;

        // Misaligned and out-of-range addresses on port 1
        bus.req1_valid = 1'b1; bus.req1_addr = 32'h6;
        #1;
        chk("e1_req1_ready", bus.req1_ready, 1);
        tick();
        bus.req1_valid = 1'b0;
        chk("e1_rom_addr", rom_addr, 32'h6);
        tick();
        chk("e1_rsp1_valid", bus.rsp1_valid, 1);
        chk("e1_rsp1_err", bus.rsp1_err, 1);
        chk("e1_rsp1_data", bus.rsp1_data, 32'h0);
        tick();
        bus.req1_valid = 1'b1; bus.req1_addr = 32'h1000;
        #1;
        chk("e2_req1_ready", bus.req1_ready, 1);
        tick();
        bus.req1_valid = 1'b0;
        chk("e2_rom_addr", rom_addr, 32'h1000);
        tick();
        chk("e2_rsp1_valid", bus.rsp1_valid, 1);
        chk("e2_rsp1_err", bus.rsp1_err, 1);
        chk("e2_rsp1_data", bus.rsp1_data, 32'h0);
        tick();

        // Port 1 response back-pressured while port 0 waits
        bus.req1_valid = 1'b1; bus.req1_addr = 32'h4; bus.rsp1_ready = 1'b0;
        #1;
        chk("bp_req1_ready", bus.req1_ready, 1);
        tick();
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_addr = 32'h8;
        #1;
        chk("bp_req0_held_read", bus.req0_ready, 0);
        tick();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d_rsp1_valid", c), bus.rsp1_valid, 1);
            chk($sformatf("bp%0d_rsp1_data", c), bus.rsp1_data, 32'hCAFE0001);
            chk($sformatf("bp%0d_rsp1_err", c), bus.rsp1_err, 0);
            chk($sformatf("bp%0d_req0_ready", c), bus.req0_ready, 0);
            chk($sformatf("bp%0d_rsp0_valid", c), bus.rsp0_valid, 0);
            if (c < 4) tick();
        end
        bus.rsp1_ready = 1'b1;
        tick();
        chk("bp_rsp1_drop", bus.rsp1_valid, 0);
        chk("bp_req0_granted", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 1'b0;
        tick();
        chk("bp_rsp0_valid", bus.rsp0_valid, 1);
        chk("bp_rsp0_data", bus.rsp0_data, 32'hDEADBEEF);
        tick();

        // Reset in the middle of READ discards the access
        bus.req0_valid = 1'b1; bus.req0_addr = 32'h4;
        tick();
        bus.req0_valid = 1'b0;
        chk("mr_busy_read", busy, 1);
        rst = 1'b1;
        #1;
        chk("mr_rom_addr", rom_addr, 32'h0);
        chk("mr_busy", busy, 0);
        chk("mr_rsp0_valid", bus.rsp0_valid, 0);
        tick();
        rst = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_addr = 32'hC;
        #1;
        chk("mr_req0_ready", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 1'b0;
        chk("mr_no_stale_rsp", bus.rsp0_valid, 0);
        chk("mr_rom_addr_new", rom_addr, 32'hC);
        tick();
        chk("mr_rsp0_valid_new", bus.rsp0_valid, 1);
        chk("mr_rsp0_data_new", bus.rsp0_data, 32'hCAFE0003);
        tick();
        chk("mr_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
